// File: rtl/sensor_debouncer.sv
// sensor_debouncer: synchronises the seven raw field switches, debounces each
// against a slow sample tick and presents clean levels with one-cycle edge
// pulses. Every output is registered; nothing downstream sees raw_inputs.
//
// Bit mapping for raw_inputs / clean / rose / fell:
//   [0] low_water_level  [1] mid_water_level  [2] high_water_level
//   [3] earth_humidity   [4] air_humidity     [5] low_temperature
//   [6] selector
module sensor_debouncer #(
    parameter int unsigned TICK_DIVISOR   = 1000,
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] raw_inputs,
    output logic [6:0] clean,
    output logic [6:0] rose,
    output logic [6:0] fell,
    output logic       any_change,
    output logic       settled
);

    localparam int unsigned PW = (TICK_DIVISOR > 1) ? $clog2(TICK_DIVISOR) : 1;
    localparam int unsigned CW = (DEBOUNCE_TICKS > 0) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIVISOR - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic [6:0]          meta;
    logic [6:0]          sync;
    logic [PW-1:0]       prescale;
    logic                tick;
    logic [6:0][CW-1:0]  count;
    logic [6:0][CW-1:0]  count_next;
    logic [6:0]          clean_next;
    logic                all_zero_next;

    // Two-flop synchroniser per channel.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= raw_inputs;
            sync <= meta;
        end
    end

    // Prescaler counting 0..TICK_DIVISOR-1; stays at 0 when the divisor is 1.
    always_ff @(posedge clock) begin
        if (reset || prescale == PRE_LAST) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + PW'(1);
        end
    end

    assign tick = (prescale == PRE_LAST);

    // Per-channel debounce: count consecutive mismatching ticks, accept on the last one.
    always_comb begin
        clean_next    = clean;
        count_next    = count;
        all_zero_next = 1'b1;
        for (int unsigned i = 0; i < 7; i++) begin
            if (tick) begin
                if (sync[i] == clean[i]) begin
                    count_next[i] = '0;
                end else if (count[i] == CNT_LAST) begin
                    clean_next[i] = sync[i];
                    count_next[i] = '0;
                end else begin
                    count_next[i] = count[i] + CW'(1);
                end
            end
            if (count_next[i] != '0) begin
                all_zero_next = 1'b0;
            end
        end
    end

    // Output and counter registers; pulses are formed from the same next-state
    // as clean so a pulse coincides with the first cycle of the new level.
    always_ff @(posedge clock) begin
        if (reset) begin
            count      <= '0;
            clean      <= '0;
            rose       <= '0;
            fell       <= '0;
            any_change <= 1'b0;
            settled    <= 1'b1;
        end else begin
            count      <= count_next;
            clean      <= clean_next;
            rose       <= clean_next & ~clean;
            fell       <= ~clean_next & clean;
            any_change <= |(clean_next ^ clean);
            settled    <= all_zero_next;
        end
    end

endmodule
